// File: rtl/rename_pkg.sv
// Shared rename/commit constants and the reorder-buffer entry layout.
// Rename and the reorder buffer both import this package.
package rename_pkg;

    localparam int PHYS_W = 6;
    localparam int ARCH_W = 5;

    // p0 is the hardwired-zero physical tag; it is never freed or woken.
    localparam logic [PHYS_W-1:0] P0 = '0;

    typedef struct packed {
        logic              valid;
        logic              complete;
        logic [ARCH_W-1:0] arch_rd;
        logic [PHYS_W-1:0] phys_rd;
        logic [PHYS_W-1:0] old_phys_rd;
    } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrapping circular-buffer pointer with increment enable and synchronous active-low reset.
module rob_ptr #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     inc,
    output logic [$clog2(DEPTH)-1:0] ptr
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = (ptr_q == IDX_W'(DEPTH - 1)) ? '0 : ptr_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/reorder_buffer.sv
// In-order commit buffer: records renamed instructions, marks them complete on wakeup, retires
// the head in program order and returns displaced tags. Define ROB_CHECK_EN for simulation checks.
module reorder_buffer
    import rename_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alloc_valid,
    input  logic [ARCH_W-1:0]        alloc_arch_rd,
    input  logic [PHYS_W-1:0]        alloc_phys_rd,
    input  logic [PHYS_W-1:0]        alloc_old_phys_rd,
    output logic                     alloc_ready,
    output logic [$clog2(DEPTH)-1:0] alloc_index,
    input  logic                     wakeup_active,
    input  logic [PHYS_W-1:0]        wakeup_tag,
    output logic                     retire_valid,
    output logic [ARCH_W-1:0]        retire_arch_rd,
    output logic [PHYS_W-1:0]        retire_phys_rd,
    output logic                     free_valid,
    output logic [PHYS_W-1:0]        free_tag,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    rob_entry_t         rob_q [DEPTH];
    rob_entry_t         rob_d [DEPTH];
    logic [CNT_W-1:0]   count_q, count_d;
    logic               empty_q, empty_d;
    logic               retire_valid_q, retire_valid_d;
    logic [ARCH_W-1:0]  retire_arch_rd_q, retire_arch_rd_d;
    logic [PHYS_W-1:0]  retire_phys_rd_q, retire_phys_rd_d;
    logic               free_valid_q, free_valid_d;
    logic [PHYS_W-1:0]  free_tag_q, free_tag_d;

    logic [IDX_W-1:0]   head_ptr;
    logic [IDX_W-1:0]   tail_ptr;
    rob_entry_t         head_entry;
    logic               alloc_fire;
    logic               retire_fire;
    logic               alloc_complete;

    // Alloc handshake: an entry is accepted on a posedge where alloc_valid && alloc_ready.
    // alloc_ready depends only on the registered count, so a retire in the same cycle does not
    // open a slot; alloc_valid without alloc_ready is dropped and changes nothing.
    assign alloc_ready = (count_q != CNT_W'(DEPTH));
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign head_entry  = rob_q[head_ptr];
    assign retire_fire = head_entry.valid && head_entry.complete;
    assign alloc_complete = (alloc_phys_rd == P0) ||
                            (wakeup_active && (wakeup_tag == alloc_phys_rd));

    rob_ptr #(.DEPTH(DEPTH)) u_head_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (retire_fire),
        .ptr   (head_ptr)
    );

    rob_ptr #(.DEPTH(DEPTH)) u_tail_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (alloc_fire),
        .ptr   (tail_ptr)
    );

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rob_d[i] = rob_q[i];
            if (wakeup_active && (wakeup_tag != P0) && rob_q[i].valid &&
                !rob_q[i].complete && (rob_q[i].phys_rd == wakeup_tag)) begin
                rob_d[i].complete = 1'b1;
            end
            if (retire_fire && (IDX_W'(i) == head_ptr)) begin
                rob_d[i] = '0;
            end
            // When full the tail equals the head, but alloc_fire is low then.
            if (alloc_fire && (IDX_W'(i) == tail_ptr)) begin
                rob_d[i].valid       = 1'b1;
                rob_d[i].complete    = alloc_complete;
                rob_d[i].arch_rd     = alloc_arch_rd;
                rob_d[i].phys_rd     = alloc_phys_rd;
                rob_d[i].old_phys_rd = alloc_old_phys_rd;
            end
        end

        count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(retire_fire);
        empty_d = (count_d == '0);

        retire_valid_d   = retire_fire;
        retire_arch_rd_d = retire_fire ? head_entry.arch_rd : '0;
        retire_phys_rd_d = retire_fire ? head_entry.phys_rd : '0;
        free_valid_d     = retire_fire && (head_entry.old_phys_rd != P0);
        free_tag_d       = free_valid_d ? head_entry.old_phys_rd : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rob_q[i] <= '0;
            end
            count_q          <= '0;
            empty_q          <= 1'b1;
            retire_valid_q   <= 1'b0;
            retire_arch_rd_q <= '0;
            retire_phys_rd_q <= '0;
            free_valid_q     <= 1'b0;
            free_tag_q       <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                rob_q[i] <= rob_d[i];
            end
            count_q          <= count_d;
            empty_q          <= empty_d;
            retire_valid_q   <= retire_valid_d;
            retire_arch_rd_q <= retire_arch_rd_d;
            retire_phys_rd_q <= retire_phys_rd_d;
            free_valid_q     <= free_valid_d;
            free_tag_q       <= free_tag_d;
        end
    end

    assign alloc_index    = tail_ptr;
    assign count          = count_q;
    assign empty          = empty_q;
    assign retire_valid   = retire_valid_q;
    assign retire_arch_rd = retire_arch_rd_q;
    assign retire_phys_rd = retire_phys_rd_q;
    assign free_valid     = free_valid_q;
    assign free_tag       = free_tag_q;

`ifdef ROB_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (alloc_valid && !alloc_ready) begin
                $fatal(1, "reorder_buffer: alloc while full");
            end
            if (count_q > CNT_W'(DEPTH)) begin
                $fatal(1, "reorder_buffer: count %0d exceeds depth", count_q);
            end
            for (int j = 0; j < DEPTH; j++) begin
                if (wakeup_active && (wakeup_tag != P0) && rob_q[j].valid &&
                    rob_q[j].complete && (rob_q[j].phys_rd == wakeup_tag)) begin
                    $fatal(1, "reorder_buffer: double wakeup of tag %0d", wakeup_tag);
                end
                if (retire_fire && (head_entry.old_phys_rd != P0) && rob_q[j].valid &&
                    (IDX_W'(j) != head_ptr) && (rob_q[j].phys_rd == head_entry.old_phys_rd)) begin
                    $fatal(1, "reorder_buffer: freeing live tag %0d", head_entry.old_phys_rd);
                end
            end
        end
    end
`else
    // Checks compiled out; cycle behaviour is identical.
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: reset, single/out-of-order retire, p0 entries, full/wrap,
// simultaneous alloc+retire and reset with pending entries.
module tb_reorder_buffer;
    import rename_pkg::*;

    localparam int DEPTH = 16;

    logic              clk;
    logic              rst_n;
    logic              alloc_valid;
    logic [ARCH_W-1:0] alloc_arch_rd;
    logic [PHYS_W-1:0] alloc_phys_rd;
    logic [PHYS_W-1:0] alloc_old_phys_rd;
    logic              alloc_ready;
    logic [3:0]        alloc_index;
    logic              wakeup_active;
    logic [PHYS_W-1:0] wakeup_tag;
    logic              retire_valid;
    logic [ARCH_W-1:0] retire_arch_rd;
    logic [PHYS_W-1:0] retire_phys_rd;
    logic              free_valid;
    logic [PHYS_W-1:0] free_tag;
    logic [4:0]        count;
    logic              empty;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;
    logic [PHYS_W-1:0] exp_q[$];

    reorder_buffer #(.DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .alloc_valid       (alloc_valid),
        .alloc_arch_rd     (alloc_arch_rd),
        .alloc_phys_rd     (alloc_phys_rd),
        .alloc_old_phys_rd (alloc_old_phys_rd),
        .alloc_ready       (alloc_ready),
        .alloc_index       (alloc_index),
        .wakeup_active     (wakeup_active),
        .wakeup_tag        (wakeup_tag),
        .retire_valid      (retire_valid),
        .retire_arch_rd    (retire_arch_rd),
        .retire_phys_rd    (retire_phys_rd),
        .free_valid        (free_valid),
        .free_tag          (free_tag),
        .count             (count),
        .empty             (empty)
    );

    // Clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        alloc_valid       = 1'b0;
        alloc_arch_rd     = '0;
        alloc_phys_rd     = '0;
        alloc_old_phys_rd = '0;
        wakeup_active     = 1'b0;
        wakeup_tag        = '0;
    endtask

    task automatic drive_alloc(input int arch, input int phys, input int old);
        alloc_valid       = 1'b1;
        alloc_arch_rd     = ARCH_W'(arch);
        alloc_phys_rd     = PHYS_W'(phys);
        alloc_old_phys_rd = PHYS_W'(old);
    endtask

    task automatic drive_wake(input int tag);
        wakeup_active = 1'b1;
        wakeup_tag    = PHYS_W'(tag);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Scoreboard: each retire must match the oldest expected phys tag.
    task automatic check_retire(input string tag, input int exp_old);
        logic [PHYS_W-1:0] exp_phys;
        check({tag, "_valid"}, 32'(retire_valid), 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            exp_phys = exp_q.pop_front();
            check({tag, "_phys"}, 32'(retire_phys_rd), 32'(exp_phys));
        end
        check({tag, "_free_valid"}, 32'(free_valid), 32'(exp_old != 0));
        check({tag, "_free_tag"}, 32'(free_tag), 32'(exp_old));
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // 1: reset state
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_ready", 32'(alloc_ready), 32'd1);
        check("rst_retire", 32'(retire_valid), 32'd0);
        check("rst_free", 32'(free_valid), 32'd0);
        check("rst_index", 32'(alloc_index), 32'd0);

        // 2: single entry, wakeup next cycle, retire two edges later
        drive_alloc(5, 32, 5);
        step();
        idle();
        check("t2_count", 32'(count), 32'd1);
        check("t2_empty", 32'(empty), 32'd0);
        drive_wake(32);
        step();
        idle();
        check("t2_no_early_retire", 32'(retire_valid), 32'd0);
        step();
        exp_q.push_back(PHYS_W'(32));
        check_retire("t2_retire", 5);
        check("t2_arch", 32'(retire_arch_rd), 32'd5);
        check("t2_count_after", 32'(count), 32'd0);
        check("t2_empty_after", 32'(empty), 32'd1);
        step();
        check("t2_pulse", 32'(retire_valid), 32'd0);

        // 3: out-of-order completion, in-order retire
        drive_alloc(1, 33, 1);
        step();
        drive_alloc(2, 34, 2);
        step();
        idle();
        exp_q.push_back(PHYS_W'(33));
        exp_q.push_back(PHYS_W'(34));
        drive_wake(34);
        step();
        check("t3_b_waits", 32'(retire_valid), 32'd0);
        drive_wake(33);
        step();
        idle();
        check("t3_a_waits", 32'(retire_valid), 32'd0);
        step();
        check_retire("t3_a", 1);
        check("t3_a_arch", 32'(retire_arch_rd), 32'd1);
        step();
        check_retire("t3_b", 2);
        check("t3_b_arch", 32'(retire_arch_rd), 32'd2);
        step();
        check("t3_idle", 32'(retire_valid), 32'd0);
        check("t3_count", 32'(count), 32'd0);

        // 4: x0/p0 entry is complete at write and frees nothing
        drive_alloc(0, 0, 0);
        step();
        idle();
        check("t4_not_yet", 32'(retire_valid), 32'd0);
        step();
        exp_q.push_back(PHYS_W'(0));
        check_retire("t4_retire", 0);

        // 5: fill to 16 starting from slot 4, tail wraps 15 -> 0
        check("t5_start_index", 32'(alloc_index), 32'd4);
        for (int i = 0; i < DEPTH; i++) begin
            drive_alloc(i + 1, 40 + i, 16 + i);
            if (i == 11) check("t5_index15", 32'(alloc_index), 32'd15);
            if (i == 12) check("t5_index0", 32'(alloc_index), 32'd0);
            step();
        end
        idle();
        check("t5_full_count", 32'(count), 32'd16);
        check("t5_full_ready", 32'(alloc_ready), 32'd0);
        check("t5_full_index", 32'(alloc_index), 32'd4);
        drive_alloc(9, 63, 9);
        step();
        idle();
        check("t5_ignored_count", 32'(count), 32'd16);
        check("t5_ignored_index", 32'(alloc_index), 32'd4);
        check("t5_ignored_retire", 32'(retire_valid), 32'd0);
        drive_wake(40);
        step();
        idle();
        step();
        exp_q.push_back(PHYS_W'(40));
        check_retire("t5_head", 16);
        check("t5_count15", 32'(count), 32'd15);
        check("t5_ready", 32'(alloc_ready), 32'd1);
        drive_wake(41);
        step();
        idle();
        check("t5_no_retire_yet", 32'(retire_valid), 32'd0);
        drive_alloc(3, 60, 3);
        step();
        idle();
        exp_q.push_back(PHYS_W'(41));
        check_retire("t5_alloc_retire", 17);
        check("t5_count_kept", 32'(count), 32'd15);
        check("t5_index5", 32'(alloc_index), 32'd5);

        // 6: reset with 5 pending entries; late wakeups are ignored
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive_alloc(i + 10, 20 + i, 10 + i);
            step();
        end
        idle();
        check("t6_pending", 32'(count), 32'd5);
        apply_reset();
        check("t6_count", 32'(count), 32'd0);
        check("t6_empty", 32'(empty), 32'd1);
        check("t6_index", 32'(alloc_index), 32'd0);
        check("t6_free", 32'(free_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive_wake(20 + i);
            step();
            check("t6_late_wake", 32'(retire_valid), 32'd0);
        end
        idle();
        step();
        check("t6_final_retire", 32'(retire_valid), 32'd0);
        check("t6_final_free", 32'(free_valid), 32'd0);
        check("t6_final_count", 32'(count), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
